// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the parametrised shift-add multiplier controller.
package mult_pkg;

    typedef enum logic [2:0] {
        RST,
        IDLE,
        LOAD,
        START,
        ADD,
        SHIFT,
        DONE
    } mult_state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Iteration counter width: max(1, clog2(width)).
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 32'd1 : int'($clog2(width));
    endfunction

endpackage

// File: rtl/mult_ctrl_param_if.sv
// Control/status bundle between the input synchroniser, the controller and the datapath.
interface mult_ctrl_param_if
    import mult_pkg::*;
#(
    parameter int unsigned CW = cnt_w(DEFAULT_WIDTH)
);
    logic          Run;
    logic          ClearA_LoadB;
    logic          M;
    logic          Signed_Mode;
    logic          Abort;
    logic          Shift_En;
    logic          LD_B;
    logic          LD_XA;
    logic          Clr_XA;
    logic          Fn;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Iter;

    modport master (
        output Run, ClearA_LoadB, M, Signed_Mode, Abort,
        input  Shift_En, LD_B, LD_XA, Clr_XA, Fn, Busy, Done, Iter
    );

    modport slave (
        input  Run, ClearA_LoadB, M, Signed_Mode, Abort,
        output Shift_En, LD_B, LD_XA, Clr_XA, Fn, Busy, Done, Iter
    );
endinterface

// File: rtl/mult_iter_cnt.sv
// Iteration counter with synchronous clear, enable and a terminal flag at WIDTH-1.
module mult_iter_cnt
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CW   = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          term
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign term = (cnt_q == CW'(WIDTH - 1));
endmodule

// File: rtl/mult_ctrl_param.sv
// Shift-add multiplier sequencer: WIDTH add/shift iterations with signed mode, abort and status.
module mult_ctrl_param
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter bit          HOLD_RUN = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    mult_ctrl_param_if.slave  bus
);
    localparam int unsigned CW = cnt_w(WIDTH);

    mult_state_e   state_q, state_d;
    logic          sgn_q, sgn_d;
    logic          cnt_clr, cnt_en, cnt_term;
    logic [CW-1:0] cnt;

    mult_iter_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk   (Clk),
        .rst_n (Reset_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .term  (cnt_term)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= RST;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sgn_d        = sgn_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        bus.Shift_En = 1'b0;
        bus.LD_B     = 1'b0;
        bus.LD_XA    = 1'b0;
        bus.Clr_XA   = 1'b0;
        bus.Fn       = 1'b0;
        bus.Busy     = 1'b0;
        bus.Done     = 1'b0;
        bus.Iter     = '0;
        unique case (state_q)
            RST: begin
                bus.Clr_XA = 1'b1;
                state_d    = IDLE;
            end
            IDLE: begin
                if (bus.Run) begin
                    state_d = START;
                end else if (bus.ClearA_LoadB) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bus.LD_B   = 1'b1;
                bus.Clr_XA = 1'b1;
                state_d    = IDLE;
            end
            START: begin
                bus.Clr_XA = 1'b1;
                bus.Busy   = 1'b1;
                sgn_d      = bus.Signed_Mode;
                cnt_clr    = 1'b1;
                state_d    = bus.Abort ? IDLE : ADD;
            end
            ADD: begin
                bus.Busy  = 1'b1;
                bus.LD_XA = bus.M;
                // Last iteration carries the sign bit: subtract in signed mode.
                bus.Fn    = sgn_q & cnt_term;
                bus.Iter  = cnt;
                if (bus.Abort) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bus.Busy     = 1'b1;
                bus.Shift_En = 1'b1;
                bus.Iter     = cnt;
                if (bus.Abort) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (cnt_term) begin
                    state_d = DONE;
                end else begin
                    cnt_en  = 1'b1;
                    state_d = ADD;
                end
            end
            DONE: begin
                bus.Done = 1'b1;
                if (!HOLD_RUN || !bus.Run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mult_ctrl_param.sv
// Self-checking bench for mult_ctrl_param: WIDTH=8/HOLD_RUN=1 and WIDTH=16/HOLD_RUN=0 instances.
module tb_mult_ctrl_param;
    import mult_pkg::*;

    localparam int unsigned W0  = 8;
    localparam int unsigned W1  = 16;
    localparam int unsigned CW0 = cnt_w(W0);
    localparam int unsigned CW1 = cnt_w(W1);

    logic Clk = 1'b0;
    logic rst0_n;
    logic rst1_n;

    always #5 Clk = ~Clk;

    mult_ctrl_param_if #(.CW(CW0)) b0 ();
    mult_ctrl_param_if #(.CW(CW1)) b1 ();

    mult_ctrl_param #(.WIDTH(W0), .HOLD_RUN(1'b1)) dut0 (
        .Clk     (Clk),
        .Reset_n (rst0_n),
        .bus     (b0)
    );

    mult_ctrl_param #(.WIDTH(W1), .HOLD_RUN(1'b0)) dut1 (
        .Clk     (Clk),
        .Reset_n (rst1_n),
        .bus     (b1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: an operation is a flat run of 2*WIDTH steps (even = add, odd = shift).
    typedef enum int {P_RST, P_IDLE, P_LOAD, P_START, P_RUN, P_DONE} phase_e;
    phase_e      ph [2];
    int unsigned kk [2];
    bit          sg [2];
    int unsigned wd [2] = '{W0, W1};
    bit          hr [2] = '{1'b1, 1'b0};

    task automatic mstep(input int i, input bit run, input bit cla, input bit sm, input bit ab);
        case (ph[i])
            P_RST:   ph[i] = P_IDLE;
            P_IDLE:  ph[i] = run ? P_START : (cla ? P_LOAD : P_IDLE);
            P_LOAD:  ph[i] = P_IDLE;
            P_START: begin
                sg[i] = sm;
                kk[i] = 0;
                ph[i] = ab ? P_IDLE : P_RUN;
            end
            P_RUN: begin
                if (ab)                         ph[i] = P_IDLE;
                else if (kk[i] == 2*wd[i] - 1)  ph[i] = P_DONE;
                else                            kk[i] = kk[i] + 1;
            end
            P_DONE:  ph[i] = (hr[i] && run) ? P_DONE : P_IDLE;
            default: ph[i] = P_IDLE;
        endcase
    endtask

    // {Clr_XA, LD_B, LD_XA, Shift_En, Fn, Busy, Done}
    function automatic logic [6:0] mexp(input int i, input logic m);
        logic [6:0] e;
        e = '0;
        case (ph[i])
            P_RST:   e = 7'b1000000;
            P_LOAD:  e = 7'b1100000;
            P_START: e = 7'b1000010;
            P_RUN: begin
                e[1] = 1'b1;
                if (kk[i] % 2 == 0) begin
                    e[4] = m;
                    e[2] = sg[i] && (kk[i] / 2 == wd[i] - 1);
                end else begin
                    e[3] = 1'b1;
                end
            end
            P_DONE:  e = 7'b0000001;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic int unsigned miter(input int i);
        return (ph[i] == P_RUN) ? kk[i] / 2 : 0;
    endfunction

    always @(posedge Clk or negedge rst0_n) begin
        if (!rst0_n) ph[0] = P_RST;
        else mstep(0, b0.Run, b0.ClearA_LoadB, b0.Signed_Mode, b0.Abort);
    end

    always @(posedge Clk or negedge rst1_n) begin
        if (!rst1_n) ph[1] = P_RST;
        else mstep(1, b1.Run, b1.ClearA_LoadB, b1.Signed_Mode, b1.Abort);
    end

    int sh0 = 0, ld0 = 0, fn0 = 0, fnld0 = 0, lditer0 = 0, dn0 = 0;
    int sh1 = 0, dn1 = 0;

    always @(negedge Clk) begin
        chk("outs0", 32'({b0.Clr_XA, b0.LD_B, b0.LD_XA, b0.Shift_En, b0.Fn, b0.Busy, b0.Done}),
            32'(mexp(0, b0.M)));
        chk("iter0", 32'(b0.Iter), miter(0));
        chk("outs1", 32'({b1.Clr_XA, b1.LD_B, b1.LD_XA, b1.Shift_En, b1.Fn, b1.Busy, b1.Done}),
            32'(mexp(1, b1.M)));
        chk("iter1", 32'(b1.Iter), miter(1));
        if (b0.Shift_En === 1'b1) sh0++;
        if (b0.Fn === 1'b1) fn0++;
        if (b0.Done === 1'b1) dn0++;
        if (b0.LD_XA === 1'b1) begin
            ld0++;
            if (b0.Fn === 1'b1) fnld0++;
            lditer0 = int'(b0.Iter);
        end
        if (b1.Shift_En === 1'b1) sh1++;
        if (b1.Done === 1'b1) dn1++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    initial begin
        ph[0] = P_RST;
        ph[1] = P_RST;
        kk[0] = 0; kk[1] = 0;
        sg[0] = 1'b0; sg[1] = 1'b0;
        {b0.Run, b0.ClearA_LoadB, b0.M, b0.Signed_Mode, b0.Abort} = '0;
        {b1.Run, b1.ClearA_LoadB, b1.M, b1.Signed_Mode, b1.Abort} = '0;
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        #1;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        #2;
        chk("rst_clr", 32'(b0.Clr_XA), 1);
        chk("rst_busy", 32'(b0.Busy), 0);
        chk("rst_iter", 32'(b0.Iter), 0);
        @(posedge Clk);
        #2;
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        chk("rst_hold_clr", 32'(b0.Clr_XA), 1);
        tick(1);
        chk("idle_clr", 32'(b0.Clr_XA), 0);

        // Unsigned, M held 1, Run held until after Done
        sh0 = 0; ld0 = 0; fn0 = 0;
        b0.M = 1'b1;
        b0.Run = 1'b1;
        tick(17);
        chk("done_t17", 32'(b0.Done), 0);
        tick(1);
        chk("done_t18", 32'(b0.Done), 1);
        chk("shift_cnt", sh0, 8);
        chk("ldxa_cnt", ld0, 8);
        chk("fn_cnt_u", fn0, 0);
        tick(3);
        chk("done_hold", 32'(b0.Done), 1);
        b0.Run = 1'b0;
        tick(1);
        chk("done_rel", 32'(b0.Done), 0);
        chk("done_rel_clr", 32'(b0.Clr_XA), 0);

        // Signed, M = 1 on iteration 7 only
        ld0 = 0; fn0 = 0; fnld0 = 0; lditer0 = 0;
        b0.M = 1'b0;
        b0.Signed_Mode = 1'b1;
        b0.Run = 1'b1;
        tick(16);
        chk("add7_iter", 32'(b0.Iter), 7);
        b0.M = 1'b1;
        tick(1);
        b0.M = 1'b0;
        b0.Signed_Mode = 1'b0;
        tick(1);
        chk("sgn_done", 32'(b0.Done), 1);
        b0.Run = 1'b0;
        tick(1);
        chk("sgn_ld_cnt", ld0, 1);
        chk("sgn_fn_ld", fnld0, 1);
        chk("sgn_ld_iter", lditer0, 7);
        chk("sgn_fn_cnt", fn0, 1);

        // Run has priority over ClearA_LoadB
        b0.Run = 1'b1;
        b0.ClearA_LoadB = 1'b1;
        tick(1);
        chk("prio_clr", 32'(b0.Clr_XA), 1);
        chk("prio_ldb", 32'(b0.LD_B), 0);
        chk("prio_busy", 32'(b0.Busy), 1);
        b0.Run = 1'b0;
        b0.ClearA_LoadB = 1'b0;
        b0.Abort = 1'b1;
        tick(1);
        b0.Abort = 1'b0;
        chk("abort_start", 32'(b0.Busy), 0);
        b0.ClearA_LoadB = 1'b1;
        tick(1);
        chk("load_ldb", 32'(b0.LD_B), 1);
        chk("load_clr", 32'(b0.Clr_XA), 1);
        b0.ClearA_LoadB = 1'b0;
        tick(1);
        chk("load_end", 32'(b0.LD_B), 0);

        // Abort in SHIFT of iteration 3
        dn0 = 0;
        b0.Run = 1'b1;
        tick(9);
        chk("ab_shift", 32'(b0.Shift_En), 1);
        chk("ab_iter", 32'(b0.Iter), 3);
        b0.Abort = 1'b1;
        b0.Run = 1'b0;
        tick(1);
        b0.Abort = 1'b0;
        chk("ab_busy", 32'(b0.Busy), 0);
        tick(4);
        chk("ab_nodone", dn0, 0);
        b0.Run = 1'b1;
        tick(2);
        chk("ab_restart_iter", 32'(b0.Iter), 0);
        chk("ab_restart_busy", 32'(b0.Busy), 1);
        b0.Run = 1'b0;
        b0.Abort = 1'b1;
        tick(1);
        b0.Abort = 1'b0;

        // Asynchronous reset mid-ADD at iteration 5
        b0.M = 1'b1;
        b0.Run = 1'b1;
        tick(12);
        chk("rst_mid_iter", 32'(b0.Iter), 5);
        chk("rst_mid_ldxa", 32'(b0.LD_XA), 1);
        #1;
        rst0_n = 1'b0;
        #1;
        chk("arst_outs", 32'({b0.Clr_XA, b0.LD_B, b0.LD_XA, b0.Shift_En, b0.Fn, b0.Busy, b0.Done}),
            32'h40);
        chk("arst_iter", 32'(b0.Iter), 0);
        b0.Run = 1'b0;
        b0.M = 1'b0;
        tick(1);
        rst0_n = 1'b1;
        chk("arst_rst_cycle", 32'(b0.Clr_XA), 1);
        tick(1);
        chk("arst_idle_clr", 32'(b0.Clr_XA), 0);
        chk("arst_idle_busy", 32'(b0.Busy), 0);

        // WIDTH=16, one-cycle Done, then automatic restart while Run stays high
        sh1 = 0; dn1 = 0;
        b1.M = 1'b1;
        b1.Run = 1'b1;
        tick(34);
        chk("w16_done", 32'(b1.Done), 1);
        chk("w16_shifts", sh1, 16);
        tick(1);
        chk("w16_idle", 32'({b1.Done, b1.Busy, b1.Clr_XA}), 0);
        tick(1);
        chk("w16_restart", 32'({b1.Clr_XA, b1.Busy}), 32'h3);
        chk("w16_done_cycles", dn1, 1);
        b1.Run = 1'b0;
        b1.Abort = 1'b1;
        tick(1);
        b1.Abort = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
